alu_mul_sequencer: RTL and testbench

- Multi-cycle 32x32 -> 64-bit shift-and-add multiplier.
- Acts as the initiator for the team's combinational 32-bit ALU. It drives the ALU command and operand ports and consumes the result and flags in the same cycle.
- Sits between a valid/ready request source and a valid/ready response sink. It is instantiated beside one ALU instance, wired port-to-port.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_sequencer.sv | 103 ++++++++++
 tb/tb_alu_mul_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU command encoding and multiplier-sequencer state encoding.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    XOR  = 3'd2,
    SLT  = 3'd3,
    AND  = 3'd4,
    NAND = 3'd5,
    NOR  = 3'd6,
    OR   = 3'd7
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add WIDTHxWIDTH multiplier that borrows an external combinational ALU for its adds.
// Define ALUSEQ_SIGNED_EN for two's-complement operands (final iteration subtracts).
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic [2:0]         alu_command,
  output logic [WIDTH-1:0]   alu_operand_a,
  output logic [WIDTH-1:0]   alu_operand_b,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_product,
  output logic               busy
);

  seq_state_t       state, state_next;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] acc_hi, acc_lo, mcand;
  logic             last_iter;
  logic             top;
  alu_cmd_t         cmd;

  // Only one of the two flags feeds the shift-in bit, depending on the build.
  logic unused_flags;
  assign unused_flags = alu_carryout ^ alu_overflow;

  assign last_iter = (counter == CNT_W'(WIDTH - 1));

`ifdef ALUSEQ_SIGNED_EN
  // True sign of the signed sum, recovered even when the ALU overflows.
  assign top = alu_result[WIDTH-1] ^ alu_overflow;
`else
  assign top = alu_carryout;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    cmd           = ADD;
    alu_operand_a = '0;
    alu_operand_b = '0;
    unique case (state)
      IDLE: if (req_valid) state_next = CALC;
      CALC: begin
        alu_operand_a = acc_hi;
        alu_operand_b = acc_lo[0] ? mcand : '0;
`ifdef ALUSEQ_SIGNED_EN
        // The multiplier sign bit carries weight -2^(WIDTH-1).
        if (last_iter && acc_lo[0]) cmd = SUB;
`endif
        if (last_iter) state_next = DONE;
      end
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign alu_command = cmd;

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: datapath registers are reset too, so rsp_product and the ALU operands start at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      mcand   <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: if (req_valid) begin
          mcand   <= req_a;
          acc_lo  <= req_b;
          acc_hi  <= '0;
          counter <= '0;
        end
        CALC: begin
          {acc_hi, acc_lo} <= {top, alu_result, acc_lo[WIDTH-1:1]};
          counter          <= counter + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = (state == IDLE);
  assign rsp_valid   = (state == DONE);
  assign busy        = (state == CALC) || (state == DONE);
  assign rsp_product = rsp_valid ? {acc_hi, acc_lo} : '0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench: sequencer beside a behavioural ALU, checked against arithmetic reference.
// Honours ALUSEQ_SIGNED_EN the same way the design does.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a, req_b;
  logic [2:0]  alu_command;
  logic [31:0] alu_operand_a, alu_operand_b;
  logic [31:0] alu_result;
  logic        alu_carryout, alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_product;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_mul_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .alu_command(alu_command), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product), .busy(busy)
  );

  // Behavioural stand-in for the team's combinational ALU.
  logic [32:0] ext;
  always_comb begin
    ext          = '0;
    alu_result   = '0;
    alu_carryout = 1'b0;
    alu_overflow = 1'b0;
    case (alu_command)
      ADD: begin
        ext          = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
        alu_result   = ext[31:0];
        alu_carryout = ext[32];
        alu_overflow = (alu_operand_a[31] == alu_operand_b[31]) && (ext[31] != alu_operand_a[31]);
      end
      SUB: begin
        ext          = {1'b0, alu_operand_a} + {1'b0, ~alu_operand_b} + 33'd1;
        alu_result   = ext[31:0];
        alu_carryout = ext[32];
        alu_overflow = (alu_operand_a[31] != alu_operand_b[31]) && (ext[31] != alu_operand_a[31]);
      end
      XOR:  alu_result = alu_operand_a ^ alu_operand_b;
      SLT:  alu_result = {31'd0, $signed(alu_operand_a) < $signed(alu_operand_b)};
      AND:  alu_result = alu_operand_a & alu_operand_b;
      NAND: alu_result = ~(alu_operand_a & alu_operand_b);
      NOR:  alu_result = ~(alu_operand_a | alu_operand_b);
      OR:   alu_result = alu_operand_a | alu_operand_b;
      default: ;
    endcase
  end

  // Reference model: full product and the upper accumulator half after i iterations,
  // i.e. (a * (b mod 2^i)) >> i, derived from the partial product rather than the datapath.
  function automatic logic [63:0] model_product(input logic [31:0] a, input logic [31:0] b);
`ifdef ALUSEQ_SIGNED_EN
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 64'(p);
`else
    return {32'd0, a} * {32'd0, b};
`endif
  endfunction

  function automatic logic [31:0] model_hi(input logic [31:0] a, input logic [31:0] b, input int i);
    logic [63:0] mask;
    mask = (64'd1 << i) - 64'd1;
`ifdef ALUSEQ_SIGNED_EN
    begin
      longint p;
      p = longint'($signed(a)) * longint'({32'd0, b} & mask);
      return 32'(p >>> i);
    end
`else
    begin
      logic [63:0] p;
      p = {32'd0, a} * ({32'd0, b} & mask);
      return 32'(p >> i);
    end
`endif
  endfunction

  function automatic logic [2:0] model_cmd(input logic [31:0] b, input int i);
`ifdef ALUSEQ_SIGNED_EN
    return (i == 31 && b[31]) ? 3'(SUB) : 3'(ADD);
`else
    return (i < 0 && b[0]) ? 3'(SUB) : 3'(ADD);
`endif
  endfunction

  // One full transaction: accept, monitor all 32 iterations, check DONE hold and handshake.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [63:0] expected,
                         input int hold, input bit keep_valid, input string name);
    logic [31:0] exp_b;
    @(negedge clk);
    req_a = a; req_b = b; req_valid = 1'b1;
    rsp_ready = (hold == 0);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL %s accept_ready: got %b want 1", name, req_ready);
    end
    @(posedge clk); #1;
    req_valid = keep_valid; req_a = $urandom; req_b = $urandom;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      exp_b = b[i] ? a : 32'd0;
      total++;
      if ({busy, req_ready, rsp_valid} !== 3'b100) begin
        bad++; $display("FAIL %s calc_status it%0d: busy/ready/valid=%b want 100", name, i,
                        {busy, req_ready, rsp_valid});
      end
      total++;
      if (alu_command !== model_cmd(b, i) || alu_operand_a !== model_hi(a, b, i) ||
          alu_operand_b !== exp_b) begin
        bad++; $display("FAIL %s alu_drive it%0d: cmd=%0d a=%h b=%h want cmd=%0d a=%h b=%h",
                        name, i, alu_command, alu_operand_a, alu_operand_b,
                        model_cmd(b, i), model_hi(a, b, i), exp_b);
      end
    end
    for (int k = 0; k <= hold; k++) begin
      if (k > 0) @(negedge clk);
      else @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_product !== expected || req_ready !== 1'b0) begin
        bad++; $display("FAIL %s done_hold%0d: valid=%b prod=%h ready=%b want 1 %h 0",
                        name, k, rsp_valid, rsp_product, req_ready, expected);
      end
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if ({req_ready, busy, rsp_valid} !== 3'b100 || rsp_product !== 64'd0) begin
      bad++; $display("FAIL %s post_handshake: ready/busy/valid=%b prod=%h want 100 0",
                      name, {req_ready, busy, rsp_valid}, rsp_product);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_a = $urandom; req_b = $urandom; rsp_ready = 1'b0;
    #12;
    total++;
    if ({req_ready, rsp_valid, busy, alu_command, alu_operand_a, alu_operand_b, rsp_product} !==
        {1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 64'd0}) begin
      bad++; $display("FAIL reset_values: ready=%b valid=%b busy=%b cmd=%0d a=%h b=%h prod=%h",
                      req_ready, rsp_valid, busy, alu_command, alu_operand_a, alu_operand_b,
                      rsp_product);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_idle_ignore();
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
      @(negedge clk);
      total++;
      if ({req_ready, busy, rsp_valid, alu_command, alu_operand_a, alu_operand_b} !==
          {1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0}) begin
        bad++; $display("FAIL idle_ignore%0d: ready=%b busy=%b valid=%b cmd=%0d a=%h b=%h", i,
                        req_ready, busy, rsp_valid, alu_command, alu_operand_a, alu_operand_b);
      end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_directed();
    run_mul(32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, 1'b0, "3x5");
    run_mul(32'h1234_5678, 32'd0, 64'd0, 10, 1'b0, "b_zero_hold");
`ifdef ALUSEQ_SIGNED_EN
    run_mul(-32'sd3, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 0, 1'b0, "neg3x5");
    run_mul(32'd5, -32'sd3, 64'hFFFF_FFFF_FFFF_FFF1, 0, 1'b0, "5xneg3");
    run_mul(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1, 1'b0, "minxmin");
`else
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 1'b0, "max_x_max");
`endif
  endtask

  task automatic test_reset_mid_calc();
    @(negedge clk);
    req_a = $urandom; req_b = $urandom | 32'h1; req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i <= 15; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, busy, alu_command, alu_operand_a, alu_operand_b, rsp_product} !==
        {1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 64'd0}) begin
      bad++; $display("FAIL midcalc_reset: ready=%b valid=%b busy=%b cmd=%0d a=%h b=%h prod=%h",
                      req_ready, rsp_valid, busy, alu_command, alu_operand_a, alu_operand_b,
                      rsp_product);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL midcalc_no_rsp cyc%0d: valid=%b busy=%b want 0 0", i, rsp_valid, busy);
      end
    end
    rsp_ready = 1'b0;
    run_mul(32'd7, 32'd9, 64'd63, 0, 1'b0, "7x9_after_reset");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int n = 0; n < 16; n++) begin
      a = $urandom; b = $urandom;
      if (n == 0) a = 32'hFFFF_FFFF;
      if (n == 1) b = 32'h8000_0000;
      run_mul(a, b, model_product(a, b), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_back_to_back();
    run_mul(32'd11, 32'd13, 64'd143, 0, 1'b1, "b2b_first");
    run_mul(32'hDEAD_BEEF, 32'h0000_0002, model_product(32'hDEAD_BEEF, 32'd2), 0, 1'b1, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_directed();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
